// File: rtl/audio_synth_mixer_pkg.sv
// Shared constants for the audio synth mixer: waveform modes, LFSR setup and
// control-word layout.
package audio_synth_pkg;
   typedef enum logic [1:0] {
      MODE_SQUARE = 2'd0,
      MODE_SAW    = 2'd1,
      MODE_TRI    = 2'd2,
      MODE_NOISE  = 2'd3
   } mode_e;

   localparam int          WAVE_W        = 8;
   localparam logic [15:0] LFSR_SEED     = 16'hACE1;
   // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10
   localparam logic [15:0] LFSR_TAPS     = 16'hB400;
   localparam int          CTRL_MODE_LSB = 0;
   localparam int          CTRL_EN_BIT   = 2;
   localparam int          CTRL_VOL_LSB  = 3;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], ^(s & LFSR_TAPS)};
   endfunction
endpackage

// File: rtl/audio_synth_mixer_if.sv
// Config/sample bus between a host and the audio synth mixer.
interface audio_synth_mixer_if #(
   parameter int NUM_VOICES = 4,
   parameter int PHASE_W    = 16,
   parameter int SAMPLE_W   = 12
);
   localparam int VSEL_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

   logic                cfg_we;
   logic [VSEL_W-1:0]   cfg_voice;
   logic                cfg_field;
   logic [PHASE_W-1:0]  cfg_data;
   logic                sync_rst;
   logic [SAMPLE_W-1:0] sample_out;
   logic                sample_valid;
   logic                pdm_out;

   modport master (
      output cfg_we, cfg_voice, cfg_field, cfg_data, sync_rst,
      input  sample_out, sample_valid, pdm_out
   );
   modport slave (
      input  cfg_we, cfg_voice, cfg_field, cfg_data, sync_rst,
      output sample_out, sample_valid, pdm_out
   );
endinterface

// File: rtl/audio_synth_mixer_voice.sv
// One synth voice: config registers, phase accumulator, noise LFSR and
// volume-scaled waveform output.
module audio_voice
   import audio_synth_pkg::*;
#(
   parameter int PHASE_W   = 16,
   parameter int VOL_W     = 4,
   parameter int VOICE_IDX = 0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      tick,
   input  logic                      sync_rst,
   input  logic                      freq_we,
   input  logic                      ctrl_we,
   input  logic [PHASE_W-1:0]        data,
   output logic [WAVE_W+VOL_W-1:0]   contrib
);
   localparam int C_W = WAVE_W + VOL_W;

   logic [PHASE_W-1:0] freq, phase;
   mode_e              mode;
   logic               en;
   logic [VOL_W-1:0]   vol;
   logic [15:0]        lfsr;
   logic [PHASE_W:0]   phase_sum;
   logic [WAVE_W-1:0]  wave;

   assign phase_sum = {1'b0, phase} + {1'b0, freq};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         freq  <= '0;
         mode  <= MODE_SQUARE;
         en    <= 1'b0;
         vol   <= '0;
         phase <= '0;
         lfsr  <= LFSR_SEED ^ 16'(VOICE_IDX);
      end else begin
         if (freq_we) freq <= data;
         if (ctrl_we) begin
            mode <= mode_e'(data[CTRL_MODE_LSB +: 2]);
            en   <= data[CTRL_EN_BIT];
            vol  <= data[CTRL_VOL_LSB +: VOL_W];
         end
         // config written this cycle only takes effect from the next tick
         if (sync_rst || !en) begin
            phase <= '0;
         end else if (tick) begin
            phase <= phase_sum[PHASE_W-1:0];
            if (phase_sum[PHASE_W]) lfsr <= lfsr_next(lfsr);
         end
      end
   end

   always_comb begin
      wave = '0;
      case (mode)
         MODE_SQUARE: wave = phase[PHASE_W-1] ? 8'hFF : 8'h00;
         MODE_SAW:    wave = phase[PHASE_W-1 -: WAVE_W];
         MODE_TRI:    wave = phase[PHASE_W-1] ? ~phase[PHASE_W-2 -: WAVE_W]
                                              :  phase[PHASE_W-2 -: WAVE_W];
         MODE_NOISE:  wave = lfsr[WAVE_W-1:0];
         default:     wave = '0;
      endcase
   end

   assign contrib = en ? ({{VOL_W{1'b0}}, wave} * {{WAVE_W{1'b0}}, vol}) : '0;
endmodule

// File: rtl/audio_synth_mixer.sv
// Multi-voice tone generator: config decode, sample tick, saturating mixer
// and first-order PDM output stage.
module audio_synth_mixer
   import audio_synth_pkg::*;
#(
   parameter int NUM_VOICES = 4,
   parameter int PHASE_W    = 16,
   parameter int VOL_W      = 4,
   parameter int SAMPLE_W   = 12,
   parameter int TICK_DIV   = 8
) (
   input  logic               clk,
   input  logic               reset,
   audio_synth_mixer_if.slave bus
);
   localparam int VSEL_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam int CNT_W   = $clog2(TICK_DIV);
   localparam int C_W     = WAVE_W + VOL_W;
   localparam int RAW_W   = C_W + $clog2(NUM_VOICES + 1);
   localparam int SUM_W   = (RAW_W > SAMPLE_W) ? RAW_W : SAMPLE_W + 1;
   localparam logic [SAMPLE_W-1:0] SAT_MAX = {SAMPLE_W{1'b1}};

   logic [CNT_W-1:0]            cnt;
   logic                        tick;
   logic [1:0]                  vld_pipe;
   logic [NUM_VOICES-1:0]       cfg_hit;
   logic [NUM_VOICES-1:0][C_W-1:0] contrib;
   logic [SUM_W-1:0]            mix;
   logic [SAMPLE_W-1:0]         mix_sat;
   logic [SAMPLE_W-1:0]         pdm_acc;
   logic [SAMPLE_W:0]           pdm_sum;

   assign tick = (cnt == CNT_W'(TICK_DIV - 1));

   // out-of-range voice numbers match no instance and are dropped
   for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
      assign cfg_hit[i] = bus.cfg_we && (bus.cfg_voice == VSEL_W'(i));
      audio_voice #(.PHASE_W(PHASE_W), .VOL_W(VOL_W), .VOICE_IDX(i)) u_voice (
         .clk      (clk),
         .reset    (reset),
         .tick     (tick),
         .sync_rst (bus.sync_rst),
         .freq_we  (cfg_hit[i] && !bus.cfg_field),
         .ctrl_we  (cfg_hit[i] &&  bus.cfg_field),
         .data     (bus.cfg_data),
         .contrib  (contrib[i])
      );
   end

   always_comb begin
      mix = '0;
      for (int i = 0; i < NUM_VOICES; i++) mix = mix + SUM_W'(contrib[i]);
      mix_sat = (mix > SUM_W'(SAT_MAX)) ? SAT_MAX : SAMPLE_W'(mix);
   end

   assign pdm_sum = {1'b0, pdm_acc} + {1'b0, bus.sample_out};
   assign bus.sample_valid = vld_pipe[1];

   // vld_pipe[0]: phases just advanced; vld_pipe[1]: sample_out holds their mix
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt            <= '0;
         vld_pipe       <= '0;
         bus.sample_out <= '0;
         pdm_acc        <= '0;
         bus.pdm_out    <= 1'b0;
      end else begin
         cnt      <= tick ? '0 : cnt + 1'b1;
         vld_pipe <= {vld_pipe[0], tick};
         if (vld_pipe[0]) bus.sample_out <= mix_sat;
         pdm_acc     <= pdm_sum[SAMPLE_W-1:0];
         bus.pdm_out <= pdm_sum[SAMPLE_W];
      end
   end
endmodule
